// File: rtl/tr_pkg.sv
// Shared definitions for the temp-register write path: TR mux source codes
// and the write-controller state encoding.
package tr_pkg;

    localparam logic [2:0] TR_SRC_BREG    = 3'd0;
    localparam logic [2:0] TR_SRC_ALUOUT  = 3'd1;
    localparam logic [2:0] TR_SRC_LSHIMM  = 3'd2;
    localparam logic [2:0] TR_SRC_SEXTIMM = 3'd3;
    localparam logic [2:0] TR_SRC_STACK   = 3'd4;
    localparam logic [2:0] TR_SRC_USER    = 3'd5;
    localparam logic [2:0] TR_SRC_ZERO    = 3'd6;
    localparam logic [2:0] TR_SRC_ILLEGAL = 3'd7;

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_IN = 1'b1
    } tr_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX; clr and reset both return it to zero,
// and clr wins over inc in the same cycle.
module sat_counter #(
    parameter int unsigned    W   = 8,
    parameter logic [W-1:0]   MAX = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/tr_write_ctrl.sv
// Arbitrates the single TR write port between the control unit, the datastack
// pop path and the user-input wait sequence; grants take effect the same cycle.
import tr_pkg::*;

module tr_write_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned STARVE_MAX  = 3,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       ctl_req,
    input  logic [2:0] ctl_src,
    output logic       ctl_gnt,
    input  logic       stk_req,
    output logic       stk_gnt,
    input  logic       inp_start,
    input  logic       in_valid,
    output logic       in_ack,
    output logic       stall,
    output logic       in_timeout,
    output logic       src_err,
    output logic [2:0] tr_src,
    output logic       tr_write,
    output tr_state_t  state
);

    localparam int unsigned      ST_W     = $clog2(STARVE_MAX + 1);
    localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(STARVE_MAX);
    localparam bit               TMO_EN   = (TIMEOUT_CYC > 0);
    localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '1;

    tr_state_t        state_q;
    tr_state_t        state_nxt;
    logic [ST_W-1:0]  starve_cnt;
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_clr;
    logic             tmo_inc;
    logic             ctl_ok;
    logic             starving;

    assign ctl_ok   = ctl_req && (ctl_src != TR_SRC_ILLEGAL);
    assign starving = stk_req && (starve_cnt == ST_MAX);

    always_comb begin
        ctl_gnt    = 1'b0;
        stk_gnt    = 1'b0;
        in_ack     = 1'b0;
        in_timeout = 1'b0;
        src_err    = 1'b0;
        stall      = 1'b0;
        tr_src     = TR_SRC_BREG;
        tmo_clr    = 1'b0;
        tmo_inc    = 1'b0;
        state_nxt  = state_q;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (inp_start) begin
                        // Input load takes priority; a ctl write issued alongside is lost.
                        stall     = 1'b1;
                        src_err   = ctl_req;
                        stk_gnt   = stk_req;
                        tmo_clr   = 1'b1;
                        state_nxt = WAIT_IN;
                    end else begin
                        src_err = ctl_req && !ctl_ok;
                        if (ctl_ok && !starving) begin
                            ctl_gnt = 1'b1;
                            tr_src  = ctl_src;
                        end else begin
                            stk_gnt = stk_req;
                            stall   = ctl_ok;
                        end
                    end
                end
                WAIT_IN: begin
                    tmo_inc = !in_valid;
                    if (in_valid) begin
                        in_ack    = 1'b1;
                        tr_src    = TR_SRC_USER;
                        state_nxt = IDLE;
                    end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
                        in_timeout = 1'b1;
                        tr_src     = TR_SRC_ZERO;
                        state_nxt  = IDLE;
                    end else begin
                        stall   = 1'b1;
                        stk_gnt = stk_req;
                    end
                end
                default: state_nxt = IDLE;
            endcase
            if (stk_gnt) begin
                tr_src = TR_SRC_STACK;
            end
        end
    end

    assign tr_write = ctl_gnt | stk_gnt | in_ack | in_timeout;
    assign state    = reset ? IDLE : state_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    sat_counter #(
        .W   (ST_W),
        .MAX (ST_MAX)
    ) u_starve_cnt (
        .clk   (CLK),
        .reset (reset),
        .clr   (!stk_req || stk_gnt),
        .inc   (stk_req && !stk_gnt),
        .cnt   (starve_cnt)
    );

    sat_counter #(
        .W   (CNT_W),
        .MAX (TMO_LAST)
    ) u_tmo_cnt (
        .clk   (CLK),
        .reset (reset),
        .clr   (tmo_clr),
        .inc   (tmo_inc),
        .cnt   (tmo_cnt)
    );

endmodule

// File: tb/tb_tr_write_ctrl.sv
// Bench for tr_write_ctrl: directed scenarios plus random traffic, scored
// per cycle against a procedural reference model through an expected queue.
import tr_pkg::*;

module tb_tr_write_ctrl;

    localparam int TMO  = 8;
    localparam int SMAX = 3;
    localparam int OW   = 11;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       ctl_req = 1'b0;
    logic [2:0] ctl_src = 3'd0;
    logic       stk_req = 1'b0;
    logic       inp_start = 1'b0;
    logic       in_valid = 1'b0;
    logic       ctl_gnt, stk_gnt, in_ack, stall, in_timeout, src_err, tr_write;
    logic [2:0] tr_src;
    tr_state_t  state;

    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] got;
    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state: waiting for input, consecutive stack losses,
    // and WAIT_IN cycles spent without valid input.
    bit m_wait   = 1'b0;
    int m_loss   = 0;
    int m_waited = 0;

    tr_write_ctrl #(
        .TIMEOUT_CYC (TMO),
        .STARVE_MAX  (SMAX),
        .CNT_W       (16)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .ctl_req    (ctl_req),
        .ctl_src    (ctl_src),
        .ctl_gnt    (ctl_gnt),
        .stk_req    (stk_req),
        .stk_gnt    (stk_gnt),
        .inp_start  (inp_start),
        .in_valid   (in_valid),
        .in_ack     (in_ack),
        .stall      (stall),
        .in_timeout (in_timeout),
        .src_err    (src_err),
        .tr_src     (tr_src),
        .tr_write   (tr_write),
        .state      (state)
    );

    always #5 CLK = ~CLK;

    assign got = {ctl_gnt, stk_gnt, in_ack, in_timeout, src_err, stall,
                  tr_src, tr_write, (state == WAIT_IN)};

    task automatic model_step(input bit rst, input bit cr, input logic [2:0] cs,
                              input bit sr, input bit is, input bit iv,
                              output logic [OW-1:0] e);
        bit cg, sg, ia, it, se, st, was_wait;
        logic [2:0] src;
        cg = 0; sg = 0; ia = 0; it = 0; se = 0; st = 0; src = 3'd0;
        was_wait = m_wait;
        if (rst) begin
            m_wait = 0; m_loss = 0; m_waited = 0; was_wait = 0;
        end else begin
            if (!m_wait) begin
                if (is) begin
                    st = 1; se = cr; sg = sr; m_wait = 1; m_waited = 0;
                end else begin
                    se = cr && (cs == 3'd7);
                    if (cr && cs != 3'd7) begin
                        if (sr && m_loss == SMAX) begin
                            sg = 1; st = 1;
                        end else begin
                            cg = 1; src = cs;
                        end
                    end else begin
                        sg = sr;
                    end
                end
            end else begin
                if (iv) begin
                    ia = 1; src = 3'd5; m_wait = 0;
                end else begin
                    m_waited++;
                    if (m_waited == TMO) begin
                        it = 1; src = 3'd6; m_wait = 0;
                    end else begin
                        st = 1; sg = sr;
                    end
                end
            end
            if (sg) src = 3'd4;
            if (sr && !sg) m_loss = (m_loss < SMAX) ? m_loss + 1 : m_loss;
            else           m_loss = 0;
        end
        e = {cg, sg, ia, it, se, st, src, (cg | sg | ia | it), was_wait};
    endtask

    task automatic drive(input bit rst, input bit cr, input logic [2:0] cs,
                         input bit sr, input bit is, input bit iv);
        logic [OW-1:0] e;
        @(posedge CLK);
        #1;
        reset = rst; ctl_req = cr; ctl_src = cs; stk_req = sr;
        inp_start = is; in_valid = iv;
        model_step(rst, cr, cs, sr, is, iv, e);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 3'd0, 0, 0, 0);
    endtask

    always @(negedge CLK) begin
        cyc++;
        if (exp_q.size() > 0) begin
            logic [OW-1:0] e;
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL out_vec cyc=%0d got=%b exp=%b (cg,sg,ack,tmo,err,stall,src[3],wr,st)",
                         cyc, got, e);
            end
        end
    end

    initial begin
        // Reset
        drive(1, 0, 3'd0, 0, 0, 0);
        drive(1, 1, 3'd2, 1, 1, 1);
        idle(1);
        // Plain ctl write
        drive(0, 1, 3'd1, 0, 0, 0);
        // Starvation: ctl and stk both held for 5 cycles
        for (int i = 0; i < 5; i++) drive(0, 1, 3'd3, 1, 0, 0);
        idle(1);
        // Input arrives 4 cycles after inp_start
        drive(0, 0, 3'd0, 0, 1, 0);
        idle(3);
        drive(0, 0, 3'd0, 0, 0, 1);
        idle(1);
        // Timeout, then late in_valid is ignored
        drive(0, 0, 3'd0, 0, 1, 0);
        idle(TMO);
        drive(0, 0, 3'd0, 0, 0, 1);
        idle(1);
        // Illegal source alongside a stack pop
        drive(0, 1, 3'd7, 1, 0, 0);
        // inp_start with ctl conflict and stk, stack pops during wait, valid beats stk
        drive(0, 1, 3'd2, 1, 1, 0);
        drive(0, 1, 3'd0, 1, 0, 0);
        drive(0, 0, 3'd0, 1, 1, 1);
        drive(0, 1, 3'd6, 1, 0, 0);
        idle(1);
        // Reset on the 2nd WAIT_IN cycle together with in_valid
        drive(0, 0, 3'd0, 0, 1, 0);
        drive(0, 0, 3'd0, 0, 0, 0);
        drive(1, 0, 3'd0, 0, 0, 1);
        idle(1);
        drive(0, 1, 3'd2, 1, 0, 0);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 11) == 0), ($urandom_range(0, 9) == 0));
        end
        idle(1);
        @(negedge CLK);
        @(negedge CLK);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tr_write_ctrl.md
Name: tr_write_ctrl

Overview:
- Sequences and arbitrates all writes into the temp-register (TR) datapath: it drives the TR source-mux select and the TR write enable.
- Shares the single TR write port between two requesters, the main control unit and the datastack pop path.
- Runs a user-input wait sequence (stall until input valid, with optional timeout) for input instructions.
- Sits between the control unit / datastack and the TR system, and drives tr_src/tr_write directly.

Parameters:
- TIMEOUT_CYC, 1024: WAIT_IN cycles before a forced zero-load. 0 disables the timeout.
- STARVE_MAX, 3: consecutive lost arbitrations after which the stack requester gets forced priority (min 1).
- CNT_W, 16: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- CLK  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- ctl_req  in  1  control unit requests a TR write this cycle
- ctl_src  in  3  source for the ctl write (0 Breg, 1 ALUout, 2 LSHIMM, 3 SEXTIMM, 4 STACK, 5 USER, 6 ZERO, 7 illegal)
- ctl_gnt  out  1  ctl write performed this cycle
- stk_req  in  1  datastack pop data ready for TR (source fixed 4)
- stk_gnt  out  1  stack write performed this cycle
- inp_start  in  1  control unit begins a user-input load
- in_valid  in  1  user input data valid on the TR user-input lane
- in_ack  out  1  input consumed this cycle
- stall  out  1  control unit must hold its state
- in_timeout  out  1  one-cycle pulse: input wait timed out, TR loaded with zero
- src_err  out  1  one-cycle pulse: illegal or conflicting ctl request dropped
- tr_src  out  3  TR mux select
- tr_write  out  1  TR register write enable

Behaviour:
- Clocking and reset:
  - Single clock CLK; reset is synchronous and active-high.
  - In a reset cycle: state goes to IDLE, starve_cnt=0, tmo_cnt=0.
  - All outputs are forced 0 during reset cycles (tr_src=0, tr_write=0).
- Latency: outputs are combinational from registered state plus current inputs. A request in cycle N writes TR at the edge closing cycle N (0-cycle grant).
- Output defaults: tr_write=0, tr_src=0 whenever nothing is granted.
- Mutual exclusion: at most one of ctl_gnt, stk_gnt, in_ack, in_timeout is high per cycle. tr_write equals the OR of those four.
- States: IDLE and WAIT_IN.
- IDLE:
  - inp_start=1: stall=1, next state WAIT_IN, tmo_cnt cleared. If ctl_req is also high, the ctl request is dropped and src_err=1. stk_req may still be granted this cycle.
  - ctl_req with ctl_src==7: no ctl grant, src_err=1. Treated as no ctl request for arbitration.
  - Arbitration: ctl wins over stk unless starve_cnt==STARVE_MAX, in which case stk wins and ctl_gnt=0 with stall=1 (control retries next cycle).
  - ctl grant drives tr_src=ctl_src. stk grant drives tr_src=4.
  - stall=0 in IDLE except in the two cases above.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when stk_req=1 and stk_gnt=0.
  - Clears on stk_gnt=1 or stk_req=0.
- WAIT_IN:
  - stall=1 every cycle except the completion cycle. ctl_req and inp_start are ignored.
  - in_valid=1: tr_write=1, tr_src=5, in_ack=1, stall=0, next state IDLE. This beats a simultaneous stk_req; stk waits and starve_cnt increments.
  - in_valid=0 and stk_req=1: stk granted (tr_src=4); state is unchanged.
  - tmo_cnt increments on every WAIT_IN cycle without in_valid.
  - Timeout, when TIMEOUT_CYC>0 and tmo_cnt==TIMEOUT_CYC-1 with in_valid=0: tr_write=1, tr_src=6, in_timeout=1, stall=0, next state IDLE. The timeout has priority over stk_req in that cycle.
- in_valid while in IDLE: ignored, in_ack=0.
- reset during WAIT_IN: return to IDLE. No in_ack and no write in the reset cycle.

Decomposition:
- Shared package tr_pkg holds:
  - TR source encodings TR_SRC_BREG=0 .. TR_SRC_ZERO=6, TR_SRC_ILLEGAL=7.
  - The state enum {IDLE, WAIT_IN}.
- One natural sub-module, sat_counter: saturating/clearable up-counter with parameter width and max. It is instantiated for both starve_cnt and tmo_cnt.

Test Plan:
- ctl_req=1, ctl_src=1 in IDLE, no stk_req -> same cycle: ctl_gnt=1, tr_write=1, tr_src=1, stall=0.
- With STARVE_MAX=3, ctl_req and stk_req held high for 5 cycles -> cycles 1-3: ctl_gnt. Cycle 4: stk_gnt=1, tr_src=4, stall=1. Cycle 5: ctl_gnt.
- inp_start pulse, in_valid asserted 4 cycles later -> stall=1 for 4 cycles. On the valid cycle: in_ack=1, tr_src=5, tr_write=1, stall=0. IDLE next cycle.
- With TIMEOUT_CYC=8, inp_start and in_valid held 0 -> 8th WAIT_IN cycle: in_timeout=1, tr_src=6, tr_write=1, stall=0. An in_valid arriving later gives in_ack=0.
- ctl_req with ctl_src=7, plus stk_req -> src_err=1, stk_gnt=1, tr_src=4, ctl_gnt=0.
- reset asserted on the 2nd WAIT_IN cycle together with in_valid -> tr_write=0, in_ack=0. Next cycle: state IDLE, stall=0, counters 0.
